shift_sequencer: RTL

Command-driven controller that wraps one `shift_register` instance and sequences it to execute multi-bit shift and rotate operations. A requester issues {op, amt, data} over a valid/ready handshake. The sequencer then drives the register's `load`, `dir`, `left`, `right` and `data` controls for the required number of cycles and signals completion. It sits between the datapath's control logic and the shift register, which has no enable input; the sequencer therefore holds the register by reloading its own output.

---
 rtl/shift_sequencer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - command sequencer driving a load/shift register for multi-bit shifts and rotates

module shift_register #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dir,
  input  logic             left,
  input  logic             right,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] out
);

  always_ff @(posedge clk) begin
    if (reset)
      out <= '0;
    else if (load)
      out <= data;
    else if (dir)
      out <= {left, out[WIDTH-1:1]};
    else
      out <= {out[WIDTH-2:0], right};
  end

endmodule

module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [AW-1:0]    cmd_amt,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_LSL  = 3'd1;
  localparam logic [2:0] OP_LSR  = 3'd2;
  localparam logic [2:0] OP_ASR  = 3'd3;
  localparam logic [2:0] OP_ROL  = 3'd4;
  localparam logic [2:0] OP_ROR  = 3'd5;

  logic [1:0]       state;
  logic [AW-1:0]    cnt;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] data_r;
  logic             err_r;

  logic             accept;
  logic             cmd_illegal;
  logic             sr_load;
  logic             sr_dir;
  logic             sr_left;
  logic             sr_right;
  logic [WIDTH-1:0] sr_data;

  assign cmd_ready   = (state != ST_EXEC);
  assign busy        = (state == ST_EXEC);
  assign done        = (state == ST_DONE);
  assign err         = done & err_r;
  assign accept      = cmd_valid & cmd_ready;
  assign cmd_illegal = (cmd_op > OP_ROR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      op_r   <= OP_LOAD;
      data_r <= '0;
      err_r  <= 1'b0;
    end else if (accept) begin
      op_r   <= cmd_op;
      data_r <= cmd_data;
      err_r  <= cmd_illegal;
      if (cmd_illegal) begin
        state <= ST_DONE;
        cnt   <= '0;
      end else if (cmd_op == OP_LOAD) begin
        state <= ST_EXEC;
        cnt   <= AW'(1);
      end else if (cmd_amt == '0) begin
        state <= ST_DONE;
        cnt   <= '0;
      end else begin
        state <= ST_EXEC;
        cnt   <= cmd_amt;
      end
    end else begin
      case (state)
        ST_EXEC: begin
          cnt <= cnt - AW'(1);
          if (cnt == AW'(1))
            state <= ST_DONE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
          err_r <= 1'b0;
        end
        ST_IDLE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The register has no enable, so anything other than an active shift reloads q.
  always_comb begin
    sr_load  = 1'b1;
    sr_dir   = 1'b0;
    sr_left  = 1'b0;
    sr_right = 1'b0;
    sr_data  = q;
    if (state == ST_EXEC) begin
      case (op_r)
        OP_LOAD: sr_data = data_r;
        OP_LSL:  sr_load = 1'b0;
        OP_LSR: begin
          sr_load = 1'b0;
          sr_dir  = 1'b1;
        end
        OP_ASR: begin
          sr_load = 1'b0;
          sr_dir  = 1'b1;
          sr_left = q[WIDTH-1];
        end
        OP_ROL: begin
          sr_load  = 1'b0;
          sr_right = q[WIDTH-1];
        end
        OP_ROR: begin
          sr_load = 1'b0;
          sr_dir  = 1'b1;
          sr_left = q[0];
        end
        default: sr_data = q;
      endcase
    end
  end

  shift_register #(.WIDTH(WIDTH)) u_shift_register (
    .clk   (clk),
    .reset (reset),
    .load  (sr_load),
    .dir   (sr_dir),
    .left  (sr_left),
    .right (sr_right),
    .data  (sr_data),
    .out   (q)
  );

endmodule
